// File: rtl/spell_pkg.sv
// spell_pkg: shared types and constants for the spell rambus slice.
//   arb_state_e   - round-robin arbiter state (ARB_IDLE, ARB_BUSY)
//   RAMBUS_*_W    - shared-RAM Wishbone widths (10-bit word addr, 32-bit data)
//   MAX_REQ       - largest number of requesters the arbiter supports
//   REQ_IDX_W     - width of a requester index
package spell_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int RAMBUS_ADDR_W = 10;
  localparam int RAMBUS_DATA_W = 32;
  localparam int RAMBUS_SEL_W  = 4;
  localparam int MAX_REQ       = 4;
  localparam int REQ_IDX_W     = $clog2(MAX_REQ);

endpackage

// File: rtl/spell_rambus_arbiter_if.sv
// spell_rambus_arbiter_if: bundle of the requester-side Wishbone ports and
// the shared rambus pins handled by spell_rambus_arbiter.
//   req_cyc/stb/we [NUM_REQ]    per-requester Wishbone controls
//   req_sel  [4*NUM_REQ]        byte selects, requester i at [4i+3:4i]
//   req_dat  [32*NUM_REQ]       write data, requester i at [32i+31:32i]
//   req_addr [10*NUM_REQ]       word address, requester i at [10i+9:10i]
//   req_ack  [NUM_REQ]          per-requester acknowledge
//   req_dat_o                   read data broadcast to every requester
//   rambus_wb_*                 shared RAM Wishbone port
// Modports: master = the arbiter (drives the rambus), slave = requesters+RAM.
interface spell_rambus_arbiter_if
  import spell_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]               req_cyc;
  logic [NUM_REQ-1:0]               req_stb;
  logic [NUM_REQ-1:0]               req_we;
  logic [RAMBUS_SEL_W*NUM_REQ-1:0]  req_sel;
  logic [RAMBUS_DATA_W*NUM_REQ-1:0] req_dat;
  logic [RAMBUS_ADDR_W*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]               req_ack;
  logic [RAMBUS_DATA_W-1:0]         req_dat_o;

  logic                     rambus_wb_clk_o;
  logic                     rambus_wb_rst_o;
  logic                     rambus_wb_stb_o;
  logic                     rambus_wb_cyc_o;
  logic                     rambus_wb_we_o;
  logic [RAMBUS_SEL_W-1:0]  rambus_wb_sel_o;
  logic [RAMBUS_DATA_W-1:0] rambus_wb_dat_o;
  logic [RAMBUS_ADDR_W-1:0] rambus_wb_addr_o;
  logic                     rambus_wb_ack_i;
  logic [RAMBUS_DATA_W-1:0] rambus_wb_dat_i;

  modport master (
    input  req_cyc, req_stb, req_we, req_sel, req_dat, req_addr,
    output req_ack, req_dat_o,
    output rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_stb_o, rambus_wb_cyc_o,
    output rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_dat_o, rambus_wb_addr_o,
    input  rambus_wb_ack_i, rambus_wb_dat_i
  );

  modport slave (
    output req_cyc, req_stb, req_we, req_sel, req_dat, req_addr,
    input  req_ack, req_dat_o,
    input  rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_stb_o, rambus_wb_cyc_o,
    input  rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_dat_o, rambus_wb_addr_o,
    output rambus_wb_ack_i, rambus_wb_dat_i
  );

endinterface

// File: rtl/spell_rr_pick.sv
// spell_rr_pick: combinational round-robin picker.
//   pending [NUM_REQ]  requesters wanting service
//   last               index served most recently (searched last)
//   valid              at least one requester pending
//   idx                chosen index: first pending in order last+1, last+2, ...
module spell_rr_pick
  import spell_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   pending,
  input  logic [REQ_IDX_W-1:0] last,
  output logic                 valid,
  output logic [REQ_IDX_W-1:0] idx
);

  // Each requester's distance from last+1 in the rotating search order;
  // the pending requester with the smallest distance wins.
  int best_d;
  int d;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    best_d = NUM_REQ;
    d      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + 2 * NUM_REQ - int'(last) - 1) % NUM_REQ;
      if (pending[i] && (d < best_d)) begin
        best_d = d;
        valid  = 1'b1;
        idx    = REQ_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/spell_rambus_arbiter.sv
// spell_rambus_arbiter: round-robin arbiter sharing the single rambus
// Wishbone port between NUM_REQ (1..4) requesters, one transaction per grant.
//   clock, reset   system clock / sync active-high reset (passed to rambus)
//   bus            spell_rambus_arbiter_if.master: requester ports + rambus
//   grant          one-hot current owner, zero while idle (registered)
//   timeout_flag   sticky BUSY-timeout indicator
// Optional feature: define SPELL_RAMBUS_TIMEOUT_EN to abort a transaction
// that sees no ack within TIMEOUT_CYCLES busy cycles (fake ack, zero data).
// Without it no counter is built and timeout_flag is tied low.
module spell_rambus_arbiter
  import spell_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  spell_rambus_arbiter_if.master bus,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  timeout_flag
);

  if (NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("NUM_REQ must be 1..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..65535");
  end

  arb_state_e             state, state_nxt;
  logic [REQ_IDX_W-1:0]   gidx, gidx_nxt;
  logic [REQ_IDX_W-1:0]   last, last_nxt;
  logic [NUM_REQ-1:0]     grant_nxt;
  logic                   pick_valid;
  logic [REQ_IDX_W-1:0]   pick_idx;

  logic                     sel_cyc, sel_stb, sel_we;
  logic [RAMBUS_SEL_W-1:0]  sel_sel;
  logic [RAMBUS_DATA_W-1:0] sel_dat;
  logic [RAMBUS_ADDR_W-1:0] sel_addr;

  assign bus.rambus_wb_clk_o = clock;
  assign bus.rambus_wb_rst_o = reset;

  spell_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .pending (bus.req_cyc & bus.req_stb),
    .last    (last),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // Forwarding mux driven by the registered owner index.
  always_comb begin
    sel_cyc  = 1'b0;
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_sel  = '0;
    sel_dat  = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == REQ_IDX_W'(i)) begin
        sel_cyc  = bus.req_cyc[i];
        sel_stb  = bus.req_stb[i];
        sel_we   = bus.req_we[i];
        sel_sel  = bus.req_sel[RAMBUS_SEL_W*i +: RAMBUS_SEL_W];
        sel_dat  = bus.req_dat[RAMBUS_DATA_W*i +: RAMBUS_DATA_W];
        sel_addr = bus.req_addr[RAMBUS_ADDR_W*i +: RAMBUS_ADDR_W];
      end
    end
  end

`ifdef SPELL_RAMBUS_TIMEOUT_EN
  logic [15:0] busy_cnt;
  logic        tmo_hit;
`endif

  always_comb begin
    state_nxt            = state;
    gidx_nxt             = gidx;
    last_nxt             = last;
    grant_nxt            = grant;
    bus.rambus_wb_cyc_o  = 1'b0;
    bus.rambus_wb_stb_o  = 1'b0;
    bus.rambus_wb_we_o   = 1'b0;
    bus.rambus_wb_sel_o  = '0;
    bus.rambus_wb_dat_o  = '0;
    bus.rambus_wb_addr_o = '0;
    bus.req_ack          = '0;
    bus.req_dat_o        = bus.rambus_wb_dat_i;
`ifdef SPELL_RAMBUS_TIMEOUT_EN
    tmo_hit              = 1'b0;
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_nxt = ARB_BUSY;
          gidx_nxt  = pick_idx;
          for (int i = 0; i < NUM_REQ; i++) grant_nxt[i] = (pick_idx == REQ_IDX_W'(i));
        end
      end
      ARB_BUSY: begin
        bus.rambus_wb_cyc_o  = sel_cyc;
        bus.rambus_wb_stb_o  = sel_stb;
        bus.rambus_wb_we_o   = sel_we;
        bus.rambus_wb_sel_o  = sel_sel;
        bus.rambus_wb_dat_o  = sel_dat;
        bus.rambus_wb_addr_o = sel_addr;
        for (int i = 0; i < NUM_REQ; i++)
          bus.req_ack[i] = bus.rambus_wb_ack_i && (gidx == REQ_IDX_W'(i));
        // Ack takes precedence over a same-cycle master abort.
        if (bus.rambus_wb_ack_i || !sel_cyc) begin
          state_nxt = ARB_IDLE;
          last_nxt  = gidx;
          grant_nxt = '0;
        end
`ifdef SPELL_RAMBUS_TIMEOUT_EN
        else if (busy_cnt == 16'(TIMEOUT_CYCLES)) begin
          tmo_hit             = 1'b1;
          bus.rambus_wb_cyc_o = 1'b0;
          bus.rambus_wb_stb_o = 1'b0;
          bus.req_dat_o       = '0;
          for (int i = 0; i < NUM_REQ; i++) bus.req_ack[i] = (gidx == REQ_IDX_W'(i));
          state_nxt = ARB_IDLE;
          last_nxt  = gidx;
          grant_nxt = '0;
        end
`endif
      end
      default: state_nxt = ARB_IDLE;
    endcase
    // Reset drops the bus in the very cycle it is asserted; no ack escapes.
    if (reset) begin
      bus.rambus_wb_cyc_o = 1'b0;
      bus.rambus_wb_stb_o = 1'b0;
      bus.req_ack         = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
      gidx  <= '0;
      last  <= REQ_IDX_W'(NUM_REQ - 1);
      grant <= '0;
    end else begin
      state <= state_nxt;
      gidx  <= gidx_nxt;
      last  <= last_nxt;
      grant <= grant_nxt;
    end
  end

`ifdef SPELL_RAMBUS_TIMEOUT_EN
  // busy_cnt is 0 in the first BUSY cycle and counts completed busy cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == ARB_BUSY) busy_cnt <= busy_cnt + 16'd1;
      else                   busy_cnt <= '0;
      if (tmo_hit) timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_spell_rambus_arbiter.sv
// tb_spell_rambus_arbiter: table-driven bench for spell_rambus_arbiter with
// NUM_REQ=2, TIMEOUT_CYCLES=8. One table row is one clock cycle: inputs are
// applied just after the rising edge and outputs compared on the falling edge.
// Requester 0: read at 0x055 (sel 1111, data CAFEF00D);
// requester 1: write 0x12345678, sel 0011 at 0x3FF. RAM read data DEADBEEF.
module tb_spell_rambus_arbiter;

  logic       clock;
  logic       reset;
  logic [1:0] grant;
  logic       timeout_flag;

  spell_rambus_arbiter_if #(.NUM_REQ(2)) bus ();

  spell_rambus_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .grant        (grant),
    .timeout_flag (timeout_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic [1:0] exp_grant;
    logic [1:0] exp_ack;
    logic [1:0] exp_own;   // 0 idle, 1 req0 forwarded, 2 req1 forwarded
    logic       exp_cs;    // rambus cyc and stb
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  logic [9:0]  e_addr;
  logic        e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_dat;

  initial begin
    //             rst cyc    stb    ack  grant  ack    own cs
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0}; // reset state
    vecs[1]  = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0}; // req0 sampled
    vecs[2]  = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'd1, 1'b1}; // busy, addr 055
    vecs[3]  = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'd1, 1'b1};
    vecs[4]  = '{1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 2'b01, 2'd1, 1'b1}; // RAM ack
    vecs[5]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0}; // re-reset
    vecs[7]  = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0}; // both request
    vecs[8]  = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 2'b01, 2'd1, 1'b1}; // req0 first
    vecs[9]  = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0}; // idle gap
    vecs[10] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b10, 2'b10, 2'd2, 1'b1}; // req1 next
    vecs[11] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 2'b01, 2'd1, 1'b1}; // req0 again
    vecs[13] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0};
    vecs[14] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b10, 2'b00, 2'd2, 1'b1}; // write forwarded
    vecs[15] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b10, 2'b10, 2'd2, 1'b1};
    vecs[16] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0};
    vecs[17] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b01, 2'b00, 2'd1, 1'b1}; // req0 busy
    vecs[18] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b01, 2'b00, 2'd1, 1'b0}; // req0 aborts
    vecs[19] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0};
    vecs[20] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b10, 2'b00, 2'd2, 1'b1}; // req1 granted
    vecs[21] = '{1'b1, 2'b10, 2'b10, 1'b1, 2'b10, 2'b00, 2'd2, 1'b0}; // reset mid-busy
    vecs[22] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0};
    vecs[23] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b01, 2'b00, 2'd1, 1'b1}; // req0 after reset
    vecs[24] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 2'b01, 2'd1, 1'b1};
    vecs[25] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0};

    reset               = 1'b1;
    bus.req_cyc         = '0;
    bus.req_stb         = '0;
    bus.req_we          = 2'b10;
    bus.req_sel         = {4'b0011, 4'b1111};
    bus.req_dat         = {32'h12345678, 32'hCAFEF00D};
    bus.req_addr        = {10'h3FF, 10'h055};
    bus.rambus_wb_ack_i = 1'b0;
    bus.rambus_wb_dat_i = 32'hDEADBEEF;
    repeat (2) next_cycle();

    for (int v = 0; v < NV; v++) begin
      reset               = vecs[v].rst;
      bus.req_cyc         = vecs[v].cyc;
      bus.req_stb         = vecs[v].stb;
      bus.rambus_wb_ack_i = vecs[v].ack;
      case (vecs[v].exp_own)
        2'd1:    begin e_addr = 10'h055; e_we = 1'b0; e_sel = 4'b1111; e_dat = 32'hCAFEF00D; end
        2'd2:    begin e_addr = 10'h3FF; e_we = 1'b1; e_sel = 4'b0011; e_dat = 32'h12345678; end
        default: begin e_addr = 10'h000; e_we = 1'b0; e_sel = 4'b0000; e_dat = 32'h0; end
      endcase
      @(negedge clock);
      chk($sformatf("v%0d grant", v), grant, vecs[v].exp_grant);
      chk($sformatf("v%0d req_ack", v), bus.req_ack, vecs[v].exp_ack);
      chk($sformatf("v%0d cyc_o", v), bus.rambus_wb_cyc_o, vecs[v].exp_cs);
      chk($sformatf("v%0d stb_o", v), bus.rambus_wb_stb_o, vecs[v].exp_cs);
      chk($sformatf("v%0d addr_o", v), bus.rambus_wb_addr_o, e_addr);
      chk($sformatf("v%0d we_o", v), bus.rambus_wb_we_o, e_we);
      chk($sformatf("v%0d sel_o", v), bus.rambus_wb_sel_o, e_sel);
      chk($sformatf("v%0d dat_o", v), bus.rambus_wb_dat_o, e_dat);
      chk($sformatf("v%0d req_dat_o", v), bus.req_dat_o, 32'hDEADBEEF);
      chk($sformatf("v%0d rst_o", v), bus.rambus_wb_rst_o, vecs[v].rst);
      chk($sformatf("v%0d timeout_flag", v), timeout_flag, 1'b0);
      next_cycle();
    end

    // Long transaction with a silent RAM.
    reset               = 1'b1;
    bus.req_cyc         = '0;
    bus.req_stb         = '0;
    bus.rambus_wb_ack_i = 1'b0;
    next_cycle();
    reset       = 1'b0;
    bus.req_cyc = 2'b01;
    bus.req_stb = 2'b01;
`ifdef SPELL_RAMBUS_TIMEOUT_EN
    begin
      int  busy_n;
      bit  seen;
      busy_n = 0;
      seen   = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
        @(negedge clock);
        if (bus.req_ack[0]) begin
          seen = 1'b1;
          chk("tmo req_dat_o", bus.req_dat_o, 32'h0);
          chk("tmo cyc_o", bus.rambus_wb_cyc_o, 1'b0);
          chk("tmo stb_o", bus.rambus_wb_stb_o, 1'b0);
          chk("tmo req_ack1", bus.req_ack[1], 1'b0);
          chk("tmo flag before edge", timeout_flag, 1'b0);
        end else begin
          if (grant[0]) busy_n++;
          next_cycle();
        end
      end
      chk("tmo ack seen", seen, 1'b1);
      chk("tmo busy cycles", busy_n, 8);
    end
    next_cycle();
    bus.req_cyc = '0;
    bus.req_stb = '0;
    @(negedge clock);
    chk("tmo flag set", timeout_flag, 1'b1);
    chk("tmo grant cleared", grant, 2'b00);
    repeat (3) next_cycle();
    @(negedge clock);
    chk("tmo flag sticky", timeout_flag, 1'b1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("tmo flag cleared by reset", timeout_flag, 1'b0);
`else
    begin
      int ack_cnt;
      int grant_ok;
      ack_cnt  = 0;
      grant_ok = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clock);
        if (bus.req_ack != 2'b00) ack_cnt++;
        if (c > 0 && grant == 2'b01 && bus.rambus_wb_stb_o) grant_ok++;
        next_cycle();
      end
      chk("wait no ack", ack_cnt, 0);
      chk("wait grant held", grant_ok, 19);
      chk("wait timeout_flag", timeout_flag, 1'b0);
    end
    bus.req_cyc = '0;
    bus.req_stb = '0;
    @(negedge clock);
    chk("wait abort grant", grant, 2'b01);
    next_cycle();
    @(negedge clock);
    chk("wait abort idle", grant, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spell_rambus_arbiter.md
# spell_rambus_arbiter

Round-robin arbiter that shares the single shared-RAM Wishbone port (10-bit word address, 32-bit data) between up to four requesting `spell` cores or other masters. Each requester presents a classic Wishbone master port. The arbiter grants one requester per transaction, forwards its signals to the RAM bus and routes the acknowledge back. It sits between the `spell_mem` instances and the top-level rambus pins.

## Interface

**Parameters**
- `NUM_REQ`, default 2: number of requesters, legal range 1–4.
- `TIMEOUT_CYCLES`, default 255: cycles in BUSY before an abort. Used only with the timeout feature. Legal range 1–65535.

**Ports**
- `clock` in 1: system clock; also driven onto `rambus_wb_clk_o`.
- `reset` in 1: synchronous, active-high; also driven onto `rambus_wb_rst_o`.
- `req_cyc` in NUM_REQ: per-requester cycle.
- `req_stb` in NUM_REQ: per-requester strobe.
- `req_we` in NUM_REQ: per-requester write enable.
- `req_sel` in 4*NUM_REQ: byte selects; requester i occupies [4i+3:4i].
- `req_dat` in 32*NUM_REQ: write data; requester i occupies [32i+31:32i].
- `req_addr` in 10*NUM_REQ: word address; requester i occupies [10i+9:10i].
- `req_ack` out NUM_REQ: per-requester acknowledge.
- `req_dat_o` out 32: read data, broadcast to all requesters.
- `rambus_wb_clk_o`, `rambus_wb_rst_o`, `rambus_wb_stb_o`, `rambus_wb_cyc_o`, `rambus_wb_we_o` out 1 each.
- `rambus_wb_sel_o` out 4.
- `rambus_wb_dat_o` out 32.
- `rambus_wb_addr_o` out 10.
- `rambus_wb_ack_i` in 1.
- `rambus_wb_dat_i` in 32.
- `grant` out NUM_REQ: one-hot current owner; all zeros in IDLE.
- `timeout_flag` out 1: sticky timeout indicator.

## Operation

- **States:** IDLE, BUSY.
- **Reset values:**
  - State = IDLE.
  - Priority pointer `last` = NUM_REQ-1, so requester 0 wins first.
  - `grant` = 0, `timeout_flag` = 0.
  - All rambus outputs = 0, except `rambus_wb_clk_o` and `rambus_wb_rst_o`, which pass through.
- **IDLE:**
  - A requester is pending when `req_cyc[i] && req_stb[i]`.
  - If any requester is pending, pick the first pending one in search order `last+1, last+2, …` modulo NUM_REQ, with `last` searched last.
  - Register its index as `gidx`, set `grant`, and go to BUSY.
  - Rambus `cyc` and `stb` are 0 in IDLE.
- **BUSY outputs:**
  - `rambus_wb_cyc_o` = `req_cyc[gidx]`.
  - `rambus_wb_stb_o` = `req_stb[gidx]`.
  - `we`, `sel`, `dat` and `addr` are muxed from slice `gidx`. The mux is combinational on the registered `gidx`.
- **BUSY acknowledge:**
  - `req_ack[gidx]` = `rambus_wb_ack_i`. All other `req_ack` bits are 0.
  - `req_dat_o` = `rambus_wb_dat_i` at all times.
- **Leaving BUSY:**
  - On `rambus_wb_ack_i`: go to IDLE, set `last` = `gidx`, clear `grant`.
  - On `req_cyc[gidx]` = 0 (master abort): go to IDLE, set `last` = `gidx`, and emit no ack.
  - If ack and abort happen in the same cycle, treat it as an ack.
- **Fairness:** the granted master loses priority to every other pending master on the next arbitration. No requester waits more than NUM_REQ-1 transactions.
- **Unselected requesters:** their `req_ack` is 0. Their strobe is held until they are granted.
- **Reset mid-transaction:** return to IDLE immediately and drop rambus `cyc`/`stb` in the reset cycle. No ack is issued.

## Timing

- Grant latency is 1 cycle. A request sampled in IDLE at edge N drives rambus `stb` in cycle N+1.
- Ack is combinational, with zero added latency from `rambus_wb_ack_i` to `req_ack`.
- After every ack or abort there is at least 1 IDLE cycle. The master has dropped `stb` by then, so a stale strobe is never re-granted.
- Back-to-back throughput is therefore (RAM latency + 1) cycles per transaction.
- `grant` is registered: it asserts in the first BUSY cycle and deasserts in the first IDLE cycle.

## Configuration

- **Macro `SPELL_RAMBUS_TIMEOUT_EN` defined:**
  - A BUSY-cycle counter clears on entry to BUSY.
  - When the counter reaches TIMEOUT_CYCLES without an ack:
    - pulse `req_ack[gidx]` for 1 cycle;
    - force `req_dat_o` to 32'h0 in that cycle;
    - drop rambus `cyc`/`stb`;
    - set `timeout_flag`;
    - go to IDLE and set `last` = `gidx`.
  - `timeout_flag` clears only on reset.
- **Macro not defined:**
  - No counter logic is built.
  - BUSY waits indefinitely for an ack or abort.
  - `timeout_flag` is tied to 0.

## Structure

- Shared package `spell_pkg`:
  - arbiter state enum (ARB_IDLE, ARB_BUSY);
  - `RAMBUS_ADDR_W` = 10, `RAMBUS_DATA_W` = 32, `RAMBUS_SEL_W` = 4;
  - `MAX_REQ` = 4.
- One sub-module, `spell_rr_pick`: combinational round-robin picker.
  - Inputs: `pending[NUM_REQ]`, `last` index.
  - Outputs: `valid`, chosen index.
  - Reusable for a future core time-slicing scheduler.

## Test plan

- **Single requester read:** NUM_REQ=2, req0 read addr 0x055, RAM acks after 2 cycles with 0xDEADBEEF. Required: `rambus_wb_addr_o`=0x055 from cycle 1; `req_ack[0]` pulses once; `req_dat_o`=0xDEADBEEF; `req_ack[1]` stays 0.
- **Simultaneous requests:** req0 and req1 both request after reset. Required: order is req0 then req1. Both held continuously give grant sequence 0,1,0,1, with exactly 1 IDLE cycle between grants.
- **Write forwarding:** req1 writes 0x12345678 with sel=4'b0011 at addr 0x3FF. Required: the rambus carries we=1, sel=0011, dat=0x12345678, addr=0x3FF, and req0 sees no ack.
- **Abort:** req0 drops `cyc` after 1 BUSY cycle with no ack. Required: IDLE next cycle, no `req_ack`, and a pending req1 is granted next.
- **Reset mid-transaction:** assert reset while in BUSY. Required: rambus `cyc`/`stb`=0 and `grant`=0 next cycle; the first grant after reset goes to req0.
- **Timeout (with `SPELL_RAMBUS_TIMEOUT_EN`, TIMEOUT_CYCLES=8):** RAM never acks. Required: `req_ack[0]` pulses after 8 BUSY cycles with `req_dat_o`=0, and `timeout_flag` stays 1 until reset.
